tg2_axi_perf_mon: RTL
=====================

Name: tg2_axi_perf_mon

Overview:
- Passive AXI-MM performance monitor on the TG2-to-EMIF user interface, in the ext_mem_if clock domain.
- Taps the AXI handshakes between the TG2 AXI master and external memory.
- Armed by the TG start pulse, frozen by TG completion.
- Accumulates beat/burst counts, error responses and read-latency statistics; results are read through a small synchronous register read port by the CSR wrapper.

Parameters:
- CNT_W, 48, width of beat/burst/latency-sum counters
- LAT_W, 16, width of single read-latency measurement and min/max registers
- TS_FIFO_DEPTH_LOG2, 5, log2 depth of the read-timestamp FIFO (32 outstanding ARs)
- LEN_W, 8, AXI awlen/arlen width

Ports:
- clk  in  1  ext_mem_if user clock
- local_rst_n_sync  in  1  asynchronous, active-low reset
- tg_start  in  1  one-cycle pulse on write to TG start register
- tg_complete  in  1  level: tg_pass|tg_fail|tg_timeout
- awvalid, awready  in  1 each  AW handshake tap
- awlen  in  LEN_W  AW burst length-1
- wvalid, wready, wlast  in  1 each  W handshake tap
- bvalid, bready  in  1 each  B handshake tap
- bresp  in  2  write response
- arvalid, arready  in  1 each  AR handshake tap
- arlen  in  LEN_W  AR burst length-1
- rvalid, rready, rlast  in  1 each  R handshake tap
- rresp  in  2  read response
- mon_addr  in  4  register select
- mon_rd  in  1  read strobe
- mon_rdata  out  64  read data, valid 1 cycle after mon_rd
- mon_rvalid  out  1  read data valid
- mon_busy  out  1  high in RUN

Behaviour:
- Reset (local_rst_n_sync low, any time): FSM=IDLE, all counters 0, lat_min=all-ones, lat_max=0, flags 0, FIFO empty, timer 0, mon_rdata=0, mon_rvalid=0, mon_busy=0.
- FSM:
  - IDLE -> RUN on tg_start.
  - RUN -> DONE on tg_complete.
  - DONE -> RUN on tg_start.
  - tg_start in any state clears all stats, flags, FIFO and timer in the same edge (restart).
  - tg_start and tg_complete in the same cycle: start wins.
- Handshake definition: a transfer counts only when valid & ready are both high on a clk edge; events are sampled only in RUN.
- Counters, in RUN:
  - aw_bursts +1 per AW handshake.
  - aw_beats += awlen+1.
  - w_beats +1 per W handshake.
  - b_cnt +1 per B handshake.
  - b_err +1 when bresp != 0.
  - ar_bursts, ar_beats, r_beats, r_err analogous.
  - r_err counts per beat with rresp != 0.
  - All counters saturate at 2^CNT_W-1; they never wrap.
- Timer: free-running LAT_W-bit cycle counter, cleared on tg_start, wraps modulo 2^LAT_W. Latency = (timer - ts) mod 2^LAT_W.
- Latency tracking:
  - Relies on the fact that TG2 issues a single ARID, so read responses are in order.
  - AR handshake in RUN pushes the timer value.
  - R handshake with rlast in RUN pops the FIFO head and computes latency. Measured from AR accept to last-beat accept; minimum 1.
  - Each pop updates lat_min, lat_max, lat_sum (saturating) and lat_cnt.
- Simultaneous push and pop: both are performed; occupancy unchanged.
- FIFO full on push: push dropped, sticky ovf flag set.
- Pop on empty: ignored, sticky unf flag set.
- Entering DONE: stats freeze. Outstanding timestamps remain but are not popped. Events in DONE/IDLE are ignored.
- Register map (mon_addr):
  - 0 status {60'b0, unf, ovf, state[1:0]} (IDLE=0, RUN=1, DONE=2)
  - 1 aw_bursts
  - 2 aw_beats
  - 3 w_beats
  - 4 b_cnt
  - 5 b_err
  - 6 ar_bursts
  - 7 ar_beats
  - 8 r_beats
  - 9 r_err
  - 10 {lat_max, lat_min} zero-extended
  - 11 lat_sum
  - 12 lat_cnt
  - 13 FIFO occupancy
  - 14-15 read 0
- Counters are zero-extended to 64 bits.
- Register read timing: mon_rdata and mon_rvalid are registered, 1-cycle latency. mon_rvalid is high exactly one cycle per mon_rd. Back-to-back reads are supported every cycle.

Test Plan:
- Reset mid-RUN with 3 outstanding ARs -> status reads 0, FIFO occupancy 0, lat_min reads 0xFFFF.
- tg_start; 4 AW bursts awlen=7 with 32 W beats and 4 B okay -> aw_bursts=4, aw_beats=32, w_beats=32, b_cnt=4, b_err=0.
- tg_start; AR at t0, rlast accepted t0+20; second AR at t0+1, rlast at t0+41 -> lat_min=20, lat_max=40, lat_sum=60, lat_cnt=2.
- 33 ARs with no R (depth 32) -> ovf=1, occupancy=32. Then an rlast with FIFO empty after draining -> unf=1.
- B with bresp=2 and an R beat with rresp=3 -> b_err=1, r_err=1. After tg_complete, further handshakes leave all counts unchanged and state=2.
- tg_start asserted in DONE with nonzero stats -> all stats cleared, state=1. Same-cycle tg_start and tg_complete -> state=1.

Source files
------------

// File: rtl/tg2_axi_perf_mon.sv
// Passive AXI-MM performance monitor for the TG2-to-EMIF user interface.
// Counts handshakes, error responses and in-order read latency between TG start and completion.
module tg2_axi_perf_mon #(
    parameter int CNT_W              = 48,
    parameter int LAT_W              = 16,
    parameter int TS_FIFO_DEPTH_LOG2 = 5,
    parameter int LEN_W              = 8
) (
    input  logic             clk,
    input  logic             local_rst_n_sync,
    input  logic             tg_start,
    input  logic             tg_complete,
    input  logic             awvalid,
    input  logic             awready,
    input  logic [LEN_W-1:0] awlen,
    input  logic             wvalid,
    input  logic             wready,
    input  logic             wlast,
    input  logic             bvalid,
    input  logic             bready,
    input  logic [1:0]       bresp,
    input  logic             arvalid,
    input  logic             arready,
    input  logic [LEN_W-1:0] arlen,
    input  logic             rvalid,
    input  logic             rready,
    input  logic             rlast,
    input  logic [1:0]       rresp,
    input  logic [3:0]       mon_addr,
    input  logic             mon_rd,
    output logic [63:0]      mon_rdata,
    output logic             mon_rvalid,
    output logic             mon_busy
);

    localparam int PTR_W = TS_FIFO_DEPTH_LOG2;
    localparam int OCC_W = TS_FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << TS_FIFO_DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
        return sat_add(a, CNT_W'(1));
    endfunction

    state_t state_q, state_d;

    logic [CNT_W-1:0] aw_bursts, aw_beats, w_beats, b_cnt, b_err;
    logic [CNT_W-1:0] ar_bursts, ar_beats, r_beats, r_err;
    logic [CNT_W-1:0] lat_sum, lat_cnt;
    logic [LAT_W-1:0] lat_min, lat_max, timer, lat;
    logic             ovf, unf;

    logic [LAT_W-1:0] ts_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;

    logic run, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic push_req, pop_req, push_ok, pop_ok, fifo_empty, fifo_full;
    logic [63:0] rd_mux;
    logic unused_taps;

    // W beats are counted individually, so wlast carries no extra information here
    assign unused_taps = wlast;

    // ---- FSM ----
    always_ff @(posedge clk or negedge local_rst_n_sync) begin
        if (!local_rst_n_sync) state_q <= ST_IDLE;
        else                   state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tg_start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (tg_complete) state_d = ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    assign run      = (state_q == ST_RUN);
    assign mon_busy = run;

    assign aw_hs = run & awvalid & awready;
    assign w_hs  = run & wvalid & wready;
    assign b_hs  = run & bvalid & bready;
    assign ar_hs = run & arvalid & arready;
    assign r_hs  = run & rvalid & rready;

    // ---- timestamp FIFO: single ARID means responses retire in AR order ----
    assign push_req   = ar_hs;
    assign pop_req    = r_hs & rlast;
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == OCC_W'(DEPTH));
    assign pop_ok     = pop_req & ~fifo_empty;
    assign push_ok    = push_req & (~fifo_full | pop_ok);
    assign lat        = timer - ts_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) ts_mem[wr_ptr] <= timer;
    end

    always_ff @(posedge clk or negedge local_rst_n_sync) begin
        if (!local_rst_n_sync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            timer  <= '0;
        end else if (tg_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            timer  <= '0;
        end else begin
            timer <= timer + LAT_W'(1);
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (push_req && !push_ok) ovf <= 1'b1;
            if (pop_req && fifo_empty) unf <= 1'b1;
        end
    end

    // ---- event counters ----
    always_ff @(posedge clk or negedge local_rst_n_sync) begin
        if (!local_rst_n_sync) begin
            aw_bursts <= '0;
            aw_beats  <= '0;
            w_beats   <= '0;
            b_cnt     <= '0;
            b_err     <= '0;
            ar_bursts <= '0;
            ar_beats  <= '0;
            r_beats   <= '0;
            r_err     <= '0;
        end else if (tg_start) begin
            aw_bursts <= '0;
            aw_beats  <= '0;
            w_beats   <= '0;
            b_cnt     <= '0;
            b_err     <= '0;
            ar_bursts <= '0;
            ar_beats  <= '0;
            r_beats   <= '0;
            r_err     <= '0;
        end else begin
            if (aw_hs) begin
                aw_bursts <= sat_inc(aw_bursts);
                aw_beats  <= sat_add(aw_beats, CNT_W'(awlen) + CNT_W'(1));
            end
            if (w_hs) w_beats <= sat_inc(w_beats);
            if (b_hs) begin
                b_cnt <= sat_inc(b_cnt);
                if (bresp != 2'b00) b_err <= sat_inc(b_err);
            end
            if (ar_hs) begin
                ar_bursts <= sat_inc(ar_bursts);
                ar_beats  <= sat_add(ar_beats, CNT_W'(arlen) + CNT_W'(1));
            end
            if (r_hs) begin
                r_beats <= sat_inc(r_beats);
                if (rresp != 2'b00) r_err <= sat_inc(r_err);
            end
        end
    end

    // ---- latency statistics ----
    always_ff @(posedge clk or negedge local_rst_n_sync) begin
        if (!local_rst_n_sync) begin
            lat_min <= '1;
            lat_max <= '0;
            lat_sum <= '0;
            lat_cnt <= '0;
        end else if (tg_start) begin
            lat_min <= '1;
            lat_max <= '0;
            lat_sum <= '0;
            lat_cnt <= '0;
        end else if (pop_ok) begin
            if (lat < lat_min) lat_min <= lat;
            if (lat > lat_max) lat_max <= lat;
            lat_sum <= sat_add(lat_sum, CNT_W'(lat));
            lat_cnt <= sat_inc(lat_cnt);
        end
    end

    // ---- register read port ----
    always_comb begin
        rd_mux = '0;
        case (mon_addr)
            4'd0:    rd_mux = {60'b0, unf, ovf, state_q};
            4'd1:    rd_mux = 64'(aw_bursts);
            4'd2:    rd_mux = 64'(aw_beats);
            4'd3:    rd_mux = 64'(w_beats);
            4'd4:    rd_mux = 64'(b_cnt);
            4'd5:    rd_mux = 64'(b_err);
            4'd6:    rd_mux = 64'(ar_bursts);
            4'd7:    rd_mux = 64'(ar_beats);
            4'd8:    rd_mux = 64'(r_beats);
            4'd9:    rd_mux = 64'(r_err);
            4'd10:   rd_mux = 64'({lat_max, lat_min});
            4'd11:   rd_mux = 64'(lat_sum);
            4'd12:   rd_mux = 64'(lat_cnt);
            4'd13:   rd_mux = 64'(occ);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge local_rst_n_sync) begin
        if (!local_rst_n_sync) begin
            mon_rdata  <= '0;
            mon_rvalid <= 1'b0;
        end else begin
            mon_rvalid <= mon_rd;
            if (mon_rd) mon_rdata <= rd_mux;
        end
    end

endmodule
